// File: rtl/sal_bank_fsm_if.sv
// ============================================================================
// Module      : sal_bank_fsm_if
// Description : Scheduler <-> bank tracker bundle: timing values, commands,
//               and per-bank legality/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sal_bank_fsm_if #(
    parameter int TW    = 8,
    parameter int ROW_W = 14
);
    logic [TW-1:0]    t_rcd;
    logic [TW-1:0]    t_rp;
    logic [TW-1:0]    t_ras;
    logic [TW-1:0]    t_rfc;
    logic [TW-1:0]    t_rtp;
    logic [TW-1:0]    t_wtp;
    logic             act_i;
    logic             rd_i;
    logic             wr_i;
    logic             pre_i;
    logic             ref_i;
    logic [ROW_W-1:0] row_i;
    logic             act_ok_o;
    logic             rdwr_ok_o;
    logic             pre_ok_o;
    logic             ref_ok_o;
    logic             row_open_o;
    logic [ROW_W-1:0] cur_row_o;
    logic             cmd_err_o;

    modport master (
        output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp,
        output act_i, rd_i, wr_i, pre_i, ref_i, row_i,
        input  act_ok_o, rdwr_ok_o, pre_ok_o, ref_ok_o,
        input  row_open_o, cur_row_o, cmd_err_o
    );

    modport slave (
        input  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp,
        input  act_i, rd_i, wr_i, pre_i, ref_i, row_i,
        output act_ok_o, rdwr_ok_o, pre_ok_o, ref_ok_o,
        output row_open_o, cur_row_o, cmd_err_o
    );
endinterface

`default_nettype wire

// File: rtl/sal_bank_fsm.sv
// ============================================================================
// Module      : sal_bank_fsm
// Description : Per-bank DDR2 state/timing tracker; reports which commands
//               the bank may legally accept each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sal_bank_fsm #(
    parameter int TW    = 8,
    parameter int ROW_W = 14
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    sal_bank_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    state_t           r_state,   w_state_nx;
    logic [TW-1:0]    r_rcd_cnt, w_rcd_nx;
    logic [TW-1:0]    r_rp_cnt,  w_rp_nx;
    logic [TW-1:0]    r_rfc_cnt, w_rfc_nx;
    logic [TW-1:0]    r_pre_cnt, w_pre_nx;
    logic [ROW_W-1:0] r_row,     w_row_nx;
    logic             r_err,     w_err;

    logic             w_act_ok, w_rdwr_ok, w_pre_ok, w_ref_ok;
    logic [2:0]       w_cmd_sum;
    logic [TW-1:0]    w_pre_dec, w_rtp_ld, w_wtp_ld, w_rfc_ld;

    // A timing value of t makes the gated command legal t cycles later; 0 behaves as 1.
    function automatic logic [TW-1:0] f_load(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    assign w_act_ok  = (r_state == ST_CLOSED) && (r_rp_cnt == '0);
    assign w_ref_ok  = (r_state == ST_CLOSED) && (r_rp_cnt == '0);
    assign w_rdwr_ok = (r_state == ST_OPEN)   && (r_rcd_cnt == '0);
    assign w_pre_ok  = (r_state == ST_OPEN)   && (r_pre_cnt == '0);

    assign w_cmd_sum = 3'(bus.act_i) + 3'(bus.rd_i) + 3'(bus.wr_i)
                     + 3'(bus.pre_i) + 3'(bus.ref_i);

    assign w_err = (w_cmd_sum > 3'd1)
                 || (bus.act_i && !w_act_ok)
                 || (bus.ref_i && !w_ref_ok)
                 || (bus.rd_i  && !w_rdwr_ok)
                 || (bus.wr_i  && !w_rdwr_ok)
                 || (bus.pre_i && !w_pre_ok);

    assign w_pre_dec = f_dec(r_pre_cnt);
    assign w_rtp_ld  = f_load(bus.t_rtp);
    assign w_wtp_ld  = f_load(bus.t_wtp);
    assign w_rfc_ld  = f_load(bus.t_rfc);

    always_comb begin
        w_state_nx = r_state;
        w_rcd_nx   = f_dec(r_rcd_cnt);
        w_rp_nx    = f_dec(r_rp_cnt);
        w_rfc_nx   = f_dec(r_rfc_cnt);
        w_pre_nx   = w_pre_dec;
        w_row_nx   = r_row;

        // Leave one cycle early so act/ref are legal exactly t_rfc cycles after REF.
        if (r_state == ST_REFRESH && r_rfc_cnt <= 1) begin
            w_state_nx = ST_CLOSED;
        end

        if (!w_err) begin
            if (bus.act_i) begin
                w_state_nx = ST_OPEN;
                w_row_nx   = bus.row_i;
                w_rcd_nx   = f_load(bus.t_rcd);
                w_pre_nx   = f_load(bus.t_ras);
            end else if (bus.ref_i) begin
                w_rfc_nx   = w_rfc_ld;
                w_state_nx = (w_rfc_ld == '0) ? ST_CLOSED : ST_REFRESH;
            end else if (bus.rd_i) begin
                w_pre_nx   = (w_rtp_ld > w_pre_dec) ? w_rtp_ld : w_pre_dec;
            end else if (bus.wr_i) begin
                w_pre_nx   = (w_wtp_ld > w_pre_dec) ? w_wtp_ld : w_pre_dec;
            end else if (bus.pre_i) begin
                w_state_nx = ST_CLOSED;
                w_rp_nx    = f_load(bus.t_rp);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLOSED;
            r_rcd_cnt <= '0;
            r_rp_cnt  <= '0;
            r_rfc_cnt <= '0;
            r_pre_cnt <= '0;
            r_row     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_rcd_cnt <= w_rcd_nx;
            r_rp_cnt  <= w_rp_nx;
            r_rfc_cnt <= w_rfc_nx;
            r_pre_cnt <= w_pre_nx;
            r_row     <= w_row_nx;
            r_err     <= w_err;
        end
    end

    assign bus.act_ok_o   = w_act_ok;
    assign bus.ref_ok_o   = w_ref_ok;
    assign bus.rdwr_ok_o  = w_rdwr_ok;
    assign bus.pre_ok_o   = w_pre_ok;
    assign bus.row_open_o = (r_state == ST_OPEN);
    assign bus.cur_row_o  = r_row;
    assign bus.cmd_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sal_bank_fsm.sv
// ============================================================================
// Module      : tb_sal_bank_fsm
// Description : Scoreboard bench for sal_bank_fsm against an absolute-time
//               reference model of the bank rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sal_bank_fsm;
    localparam int TW    = 8;
    localparam int ROW_W = 14;
    localparam logic [4:0] C_IDLE = 5'b00000, C_ACT = 5'b00001, C_RD = 5'b00010,
                           C_WR = 5'b00100, C_PRE = 5'b01000, C_REF = 5'b10000;

    typedef logic [ROW_W+5:0] obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sal_bank_fsm_if #(.TW(TW), .ROW_W(ROW_W)) bus ();
    sal_bank_fsm #(.TW(TW), .ROW_W(ROW_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: absolute cycle numbers from which each gated command becomes legal.
    int               m_st;     // 0 closed, 1 open, 2 refresh
    int               now;
    int               rp_until, rcd_until, pre_until, rfc_until;
    logic [ROW_W-1:0] m_row;
    bit               m_err;

    function automatic int eff(input logic [TW-1:0] t);
        return (t == 0) ? 1 : int'(t);
    endfunction

    function automatic void model_reset();
        m_st = 0; rp_until = 0; rcd_until = 0; pre_until = 0; rfc_until = 0;
        m_row = '0; m_err = 1'b0;
    endfunction

    function automatic obs_t model_out();
        bit aok, rdok, pok;
        if (m_st == 2 && now >= rfc_until) m_st = 0;
        aok  = (m_st == 0) && (now >= rp_until);
        rdok = (m_st == 1) && (now >= rcd_until);
        pok  = (m_st == 1) && (now >= pre_until);
        return {aok, rdok, pok, aok, (m_st == 1), m_row, m_err};
    endfunction

    function automatic void model_apply(input logic [4:0] c, input logic [ROW_W-1:0] row);
        obs_t o;
        int   n;
        bit   aok, rdok, pok, bad;
        o    = model_out();
        aok  = o[ROW_W+5];
        rdok = o[ROW_W+4];
        pok  = o[ROW_W+3];
        n    = int'(c[0]) + int'(c[1]) + int'(c[2]) + int'(c[3]) + int'(c[4]);
        bad  = (n > 1) || (c[0] && !aok) || (c[1] && !rdok) || (c[2] && !rdok)
            || (c[3] && !pok) || (c[4] && !aok);
        m_err = bad;
        if (!bad) begin
            if (c[0]) begin
                m_st = 1; m_row = row;
                rcd_until = now + eff(bus.t_rcd);
                pre_until = now + eff(bus.t_ras);
            end else if (c[1]) begin
                if (now + eff(bus.t_rtp) > pre_until) pre_until = now + eff(bus.t_rtp);
            end else if (c[2]) begin
                if (now + eff(bus.t_wtp) > pre_until) pre_until = now + eff(bus.t_wtp);
            end else if (c[3]) begin
                m_st = 0; rp_until = now + eff(bus.t_rp);
            end else if (c[4]) begin
                m_st = 2; rfc_until = now + eff(bus.t_rfc);
            end
        end
    endfunction

    function automatic obs_t dut_obs();
        return {bus.act_ok_o, bus.rdwr_ok_o, bus.pre_ok_o, bus.ref_ok_o,
                bus.row_open_o, bus.cur_row_o, bus.cmd_err_o};
    endfunction

    task automatic chk(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t got=%h expected=%h (ok{act,rdwr,pre,ref},open,row,err)",
                     name, $time, got, exp);
        end
    endtask

    // Monitor: the DUT presents its status every cycle; compare each against the queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) chk("cycle_status", dut_obs(), exp_q.pop_front());
        end
    end

    task automatic set_t(input int rcd, input int rp, input int ras,
                         input int rfc, input int rtp, input int wtp);
        bus.t_rcd = TW'(rcd); bus.t_rp  = TW'(rp);  bus.t_ras = TW'(ras);
        bus.t_rfc = TW'(rfc); bus.t_rtp = TW'(rtp); bus.t_wtp = TW'(wtp);
    endtask

    task automatic step(input logic [4:0] c, input logic [ROW_W-1:0] row);
        exp_q.push_back(model_out());
        {bus.ref_i, bus.pre_i, bus.wr_i, bus.rd_i, bus.act_i} = c;
        bus.row_i = row;
        model_apply(c, row);
        @(posedge clk); #1;
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(C_IDLE, '0);
    endtask

    task automatic do_reset();
        {bus.ref_i, bus.pre_i, bus.wr_i, bus.rd_i, bus.act_i} = C_IDLE;
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_obs(), {5'b10010, {ROW_W{1'b0}}, 1'b0});
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        now++;
    endtask

    function automatic logic [4:0] pick_cmd();
        obs_t       o;
        logic [4:0] cand[$];
        int         r;
        o = model_out();
        r = $urandom_range(0, 99);
        if (r < 8)  return 5'($urandom);
        if (r < 45) return C_IDLE;
        if (o[ROW_W+5]) begin
            cand.push_back(C_ACT); cand.push_back(C_ACT); cand.push_back(C_REF);
        end
        if (o[ROW_W+4]) begin cand.push_back(C_RD); cand.push_back(C_WR); end
        if (o[ROW_W+3]) cand.push_back(C_PRE);
        if (cand.size() == 0) return C_IDLE;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    initial begin
        now = 0;
        model_reset();
        set_t(3, 3, 8, 20, 2, 6);
        {bus.ref_i, bus.pre_i, bus.wr_i, bus.rd_i, bus.act_i} = C_IDLE;
        bus.row_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        idle(2);
        // ACT, then WR at +7: write recovery holds PRE off past tRAS
        step(C_ACT, 14'h1A5); idle(6); step(C_WR, '0); idle(7); step(C_PRE, '0); idle(3);
        // ACT, RD at +7, PRE at +10, premature ACT at +12
        step(C_ACT, 14'h0333); idle(6); step(C_RD, '0); idle(2); step(C_PRE, '0);
        idle(1); step(C_ACT, 14'h0077); idle(3);
        // Refresh from idle bank
        step(C_REF, '0); idle(22);
        // tRCD of 0 and 1, plus illegal/multi commands
        set_t(0, 3, 8, 20, 2, 6);
        step(C_ACT, 14'h0011); step(C_RD, '0); idle(8); step(C_PRE, '0); idle(3);
        set_t(1, 3, 8, 20, 2, 6);
        step(C_ACT, 14'h0022); step(C_WR, '0); idle(3);
        step(C_RD | C_PRE, '0); idle(12); step(C_PRE, '0); idle(3);
        step(C_ACT | C_RD, 14'h3FFF); step(C_RD, '0); step(C_PRE, '0); idle(2);
        // Reset mid-REFRESH and mid-OPEN
        set_t(3, 3, 8, 20, 2, 6);
        step(C_REF, '0); idle(5); do_reset();
        step(C_ACT, 14'h2AAA); idle(4); do_reset();
        step(C_ACT, 14'h1555); idle(3);

        // Randomised commands and timing values
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0)
                set_t($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 14),
                      $urandom_range(0, 25), $urandom_range(0, 8), $urandom_range(0, 12));
            step(pick_cmd(), ROW_W'($urandom));
        end
        idle(2);
        @(negedge clk); #1;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
